// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM command-port initiator: mosi field layout,
// widths, FSM state type and a mosi packing helper.
package sram_pkg;
   localparam int unsigned MOSI_W      = 36;
   localparam int unsigned HW_W        = 16;
   localparam int unsigned WORD_W      = 32;
   localparam int unsigned WORD_ADDR_W = 18;
   localparam int unsigned RW_BIT      = 35;
   localparam int unsigned DATA_MSB    = 34;
   localparam int unsigned DATA_LSB    = 19;
   localparam int unsigned ADDR_MSB    = 18;
   localparam int unsigned ADDR_LSB    = 0;

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

   function automatic logic [MOSI_W-1:0] pack_mosi(input logic rw,
                                                   input logic [HW_W-1:0] data,
                                                   input logic [ADDR_MSB:ADDR_LSB] addr);
      return {rw, data, addr};
   endfunction
endpackage

// File: rtl/sram_master_if.sv
// CPU-side request/response bus plus the SRAM command port, bundled for sram_master.
interface sram_master_if;
   import sram_pkg::*;

   logic                   cpu_req;
   logic                   cpu_we;
   logic [WORD_ADDR_W-1:0] cpu_addr;
   logic [WORD_W-1:0]      cpu_wdata;
   logic                   cpu_ready;
   logic                   cpu_ack;
   logic [WORD_W-1:0]      cpu_rdata;
   logic                   cs_n;
   logic [MOSI_W-1:0]      mosi;
   logic [HW_W-1:0]        miso;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, miso,
      output cpu_ready, cpu_ack, cpu_rdata, cs_n, mosi
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, miso,
      input  cpu_ready, cpu_ack, cpu_rdata, cs_n, mosi
   );
endinterface

// File: rtl/sram_master.sv
// Splits 32-bit CPU word accesses into two 16-bit SRAM accesses (low half first)
// with setup / access / hold phasing and a one-cycle completion pulse.
module sram_master
   import sram_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic          sck,
   input  logic          rst,
   sram_master_if.master bus
);
   localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   state_t                 state, state_next;
   logic [CNT_W-1:0]       cnt;
   logic                   half;
   logic                   we_q;
   logic [WORD_ADDR_W-1:0] addr_q;
   logic [HW_W-1:0]        wdata_hi_q;
   logic                   access_last;

   assign access_last   = (cnt == CNT_LAST);
   assign bus.cpu_ready = (state == IDLE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.cpu_req) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  if (access_last) state_next = HOLD;
         HOLD:    state_next = half ? DONE : SETUP;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // cs_n and cpu_ack are registered from the next state so they line up
   // exactly with the state they belong to.
   always_ff @(posedge sck or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         half          <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_hi_q    <= '0;
         bus.cs_n      <= 1'b1;
         bus.mosi      <= '0;
         bus.cpu_ack   <= 1'b0;
         bus.cpu_rdata <= '0;
      end else begin
         state       <= state_next;
         bus.cs_n    <= (state_next != ACCESS);
         bus.cpu_ack <= (state_next == DONE);
         case (state)
            IDLE: begin
               if (bus.cpu_req) begin
                  we_q       <= bus.cpu_we;
                  addr_q     <= bus.cpu_addr;
                  wdata_hi_q <= bus.cpu_wdata[WORD_W-1:HW_W];
                  half       <= 1'b0;
                  cnt        <= '0;
                  bus.mosi   <= pack_mosi(bus.cpu_we, bus.cpu_wdata[HW_W-1:0],
                                          {bus.cpu_addr, 1'b0});
               end
            end
            ACCESS: begin
               if (access_last) begin
                  cnt <= '0;
                  if (!we_q) begin
                     if (half) bus.cpu_rdata[WORD_W-1:HW_W] <= bus.miso;
                     else      bus.cpu_rdata[HW_W-1:0]      <= bus.miso;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (!half) begin
                  half     <= 1'b1;
                  bus.mosi <= pack_mosi(we_q, wdata_hi_q, {addr_q, 1'b1});
               end else begin
                  bus.mosi[RW_BIT] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_master.sv
// Self-checking bench for sram_master: behavioural SRAM slave, halfword reference
// memory, mosi-stability monitor, and directed plus randomized transactions.
module tb_sram_master;
   import sram_pkg::*;

   logic sck = 1'b0;
   logic rst = 1'b0;
   always #5 sck = ~sck;

   int tests = 0;
   int fails = 0;

   sram_master_if if0 ();
   sram_master_if if1 ();

   sram_master #(.WAIT_CYCLES(2)) dut0 (.sck(sck), .rst(rst), .bus(if0.master));
   sram_master #(.WAIT_CYCLES(1)) dut1 (.sck(sck), .rst(rst), .bus(if1.master));

   // sel picks which DUT the stimulus, slave and observations are attached to
   bit          sel = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [17:0] addr = '0;
   logic [31:0] wdata = '0;

   assign if0.cpu_req   = req & ~sel;
   assign if1.cpu_req   = req & sel;
   assign if0.cpu_we    = we;
   assign if1.cpu_we    = we;
   assign if0.cpu_addr  = addr;
   assign if1.cpu_addr  = addr;
   assign if0.cpu_wdata = wdata;
   assign if1.cpu_wdata = wdata;

   logic        cs_s, ack_s, ready_s;
   logic [35:0] mosi_s;
   logic [31:0] rdata_s;
   assign cs_s    = sel ? if1.cs_n      : if0.cs_n;
   assign ack_s   = sel ? if1.cpu_ack   : if0.cpu_ack;
   assign ready_s = sel ? if1.cpu_ready : if0.cpu_ready;
   assign mosi_s  = sel ? if1.mosi      : if0.mosi;
   assign rdata_s = sel ? if1.cpu_rdata : if0.cpu_rdata;

   // Behavioural SRAM slave: combinational read while selected, write on the clock.
   bit   [15:0] mem [0:524287];
   logic [15:0] miso_v;
   bit          pre_en = 1'b0;
   logic [18:0] pre_a = '0;
   logic [15:0] pre_d = '0;
   assign miso_v   = cs_s ? 16'h0000 : mem[mosi_s[18:0]];
   assign if0.miso = miso_v;
   assign if1.miso = miso_v;

   always @(posedge sck) begin
      if (pre_en) mem[pre_a] <= pre_d;
      else if (!cs_s && mosi_s[35]) mem[mosi_s[18:0]] <= mosi_s[34:19];
   end

   // Monitor: mosi must not move while cs_n is low or on the cycle cs_n rises.
   int          viol = 0;
   int unsigned runs[$];
   logic [35:0] words[$];
   logic        prev_cs = 1'b1;
   logic [35:0] prev_mosi = '0;
   int unsigned low_len = 0;
   always @(negedge sck) begin
      if (!rst) begin
         if (!prev_cs && mosi_s !== prev_mosi) viol++;
         if (!cs_s) begin
            if (prev_cs) begin
               low_len = 1;
               words.push_back(mosi_s);
            end else begin
               low_len++;
            end
         end else if (!prev_cs) begin
            runs.push_back(low_len);
         end
      end
      prev_cs   = cs_s;
      prev_mosi = mosi_s;
   end

   // Reference memory at halfword granularity; word a occupies halfwords 2a, 2a+1.
   logic [15:0] ref_hw [int unsigned];

   function automatic logic [15:0] ref_get(input logic [18:0] ha);
      if (ref_hw.exists(32'(ha))) return ref_hw[32'(ha)];
      return 16'h0000;
   endfunction

   function automatic logic [31:0] ref_word(input logic [17:0] a);
      return {ref_get({a, 1'b1}), ref_get({a, 1'b0})};
   endfunction

   function automatic int unsigned wc_now();
      return sel ? 1 : 2;
   endfunction

   task automatic wait_ready(input string tag);
      int unsigned n = 0;
      while (ready_s !== 1'b1 && n < 30) begin
         @(negedge sck);
         n++;
      end
      tests++;
      if (ready_s !== 1'b1) begin
         fails++;
         $display("FAIL %s ready_timeout got=%b want=1", tag, ready_s);
      end
   endtask

   task automatic preload(input logic [18:0] ha, input logic [15:0] d);
      @(negedge sck);
      pre_en = 1'b1; pre_a = ha; pre_d = d;
      @(posedge sck);
      #1 pre_en = 1'b0;
      ref_hw[32'(ha)] = d;
   endtask

   task automatic run_txn(input logic w, input logic [17:0] a, input logic [31:0] d,
                          input string tag);
      int unsigned wc = wc_now();
      int unsigned r0, w0, k;
      int          v0;
      bit          got, held_bad;
      logic [31:0] rd_before, exp_rd;
      logic [35:0] exp0, exp1;
      @(negedge sck);
      wait_ready(tag);
      r0 = runs.size(); w0 = words.size(); v0 = viol; rd_before = rdata_s;
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge sck);
      #1;
      req = 1'b0; we = 1'($urandom); addr = 18'($urandom); wdata = $urandom;
      got = 1'b0; held_bad = 1'b0; k = 0;
      while (!got && k < 40) begin
         @(negedge sck);
         k++;
         if (w && rdata_s !== rd_before) held_bad = 1'b1;
         if (ack_s === 1'b1) got = 1'b1;
      end
      tests++;
      if (!got || k != 2*wc+5) begin
         fails++; $display("FAIL %s ack_latency got=%0d want=%0d", tag, got ? k : 0, 2*wc+5);
      end
      tests++;
      if (ready_s !== 1'b0 || cs_s !== 1'b1 || mosi_s[35] !== 1'b0) begin
         fails++;
         $display("FAIL %s done_outputs got ready=%b cs_n=%b rw=%b want 0 1 0", tag, ready_s, cs_s, mosi_s[35]);
      end
      exp_rd = w ? rd_before : ref_word(a);
      tests++;
      if (rdata_s !== exp_rd || held_bad) begin
         fails++; $display("FAIL %s rdata got=%h want=%h held_bad=%b", tag, rdata_s, exp_rd, held_bad);
      end
      tests++;
      if (runs.size() != r0 + 2 || runs[r0] != wc || runs[r0+1] != wc) begin
         fails++;
         $display("FAIL %s cs_low_runs got_count=%0d want 2 runs of %0d", tag, runs.size() - r0, wc);
      end
      exp0 = {w, d[15:0], a, 1'b0};
      exp1 = {w, d[31:16], a, 1'b1};
      tests++;
      if (words.size() != w0 + 2 || words[w0] !== exp0 || words[w0+1] !== exp1) begin
         fails++;
         $display("FAIL %s mosi_words got=%h,%h want=%h,%h", tag,
                  (words.size() > w0) ? words[w0] : 36'h0,
                  (words.size() > w0 + 1) ? words[w0+1] : 36'h0, exp0, exp1);
      end
      tests++;
      if (viol != v0) begin
         fails++; $display("FAIL %s mosi_stable got=%0d changes want=0", tag, viol - v0);
      end
      @(negedge sck);
      tests++;
      if (ready_s !== 1'b1 || ack_s !== 1'b0 || mosi_s[35] !== 1'b0) begin
         fails++;
         $display("FAIL %s after_done got ready=%b ack=%b rw=%b want 1 0 0", tag, ready_s, ack_s, mosi_s[35]);
      end
      if (w) begin
         ref_hw[32'({a, 1'b0})] = d[15:0];
         ref_hw[32'({a, 1'b1})] = d[31:16];
      end
   endtask

   task automatic abort_txn(input logic w, input logic [17:0] a, input logic [31:0] d,
                            input int unsigned cyc, input bit lo_done, input string tag);
      int unsigned wc = wc_now();
      int          seen = 0;
      @(negedge sck);
      wait_ready(tag);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge sck);
      #1 req = 1'b0;
      repeat (cyc) @(negedge sck);
      tests++;
      if (cs_s !== 1'b0) begin
         fails++; $display("FAIL %s in_access cs_n got=%b want=0", tag, cs_s);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (cs_s !== 1'b1 || mosi_s !== 36'h0 || ack_s !== 1'b0 || ready_s !== 1'b1 || rdata_s !== 32'h0) begin
         fails++;
         $display("FAIL %s async_reset got cs_n=%b mosi=%h ack=%b ready=%b rdata=%h want 1 0 0 1 0",
                  tag, cs_s, mosi_s, ack_s, ready_s, rdata_s);
      end
      @(posedge sck);
      @(negedge sck);
      rst = 1'b0;
      repeat (2*wc + 8) begin
         @(negedge sck);
         if (ack_s !== 1'b0) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++; $display("FAIL %s no_ack_after_abort got=%0d acks want=0", tag, seen);
      end
      if (w && lo_done) ref_hw[32'({a, 1'b0})] = d[15:0];
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      tests++;
      if (if0.cs_n !== 1'b1 || if0.mosi !== 36'h0 || if0.cpu_ack !== 1'b0 ||
          if0.cpu_ready !== 1'b1 || if0.cpu_rdata !== 32'h0) begin
         fails++;
         $display("FAIL reset_dut0 got cs_n=%b mosi=%h ack=%b ready=%b rdata=%h want 1 0 0 1 0",
                  if0.cs_n, if0.mosi, if0.cpu_ack, if0.cpu_ready, if0.cpu_rdata);
      end
      tests++;
      if (if1.cs_n !== 1'b1 || if1.mosi !== 36'h0 || if1.cpu_ack !== 1'b0 || if1.cpu_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_dut1 got cs_n=%b mosi=%h ack=%b ready=%b want 1 0 0 1",
                  if1.cs_n, if1.mosi, if1.cpu_ack, if1.cpu_ready);
      end
      repeat (2) @(negedge sck);
      rst = 1'b0;
   endtask

   task automatic test_write();
      run_txn(1'b1, 18'h00010, 32'hDEADBEEF, "write");
   endtask

   task automatic test_read();
      preload(19'h7FFFE, 16'h1234);
      preload(19'h7FFFF, 16'hABCD);
      run_txn(1'b0, 18'h3FFFF, 32'h0, "read_top");
      tests++;
      if (rdata_s !== 32'hABCD1234) begin
         fails++; $display("FAIL read_top_const got=%h want=abcd1234", rdata_s);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned wc = wc_now();
      int unsigned per = 2*wc + 6;
      int unsigned ack1 = 0, ack2 = 0, nack = 0, nready = 0, ready_at = 0;
      bit          held_bad = 1'b0;
      logic [17:0] a = 18'($urandom);
      logic [31:0] d = $urandom;
      logic [31:0] rd_before;
      @(negedge sck);
      wait_ready("b2b");
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      rd_before = rdata_s;
      @(posedge sck);
      #1 we = 1'b0;
      for (int unsigned k = 1; k <= 2*per - 1; k++) begin
         @(negedge sck);
         if (k == per + 1) req = 1'b0;
         if (k < per && rdata_s !== rd_before) held_bad = 1'b1;
         if (ready_s === 1'b1) begin nready++; ready_at = k; end
         if (ack_s === 1'b1) begin
            nack++;
            if (ack1 == 0) ack1 = k; else ack2 = k;
         end
      end
      tests++;
      if (nack != 2 || ack1 != 2*wc+5 || ack2 != 2*per-1) begin
         fails++;
         $display("FAIL b2b_acks got n=%0d at %0d,%0d want 2 at %0d,%0d", nack, ack1, ack2, 2*wc+5, 2*per-1);
      end
      tests++;
      if (nready != 1 || ready_at != per) begin
         fails++; $display("FAIL b2b_ready got n=%0d at %0d want 1 at %0d", nready, ready_at, per);
      end
      tests++;
      if (held_bad) begin
         fails++; $display("FAIL b2b_rdata_held got changed want=%h", rd_before);
      end
      tests++;
      if (rdata_s !== d) begin
         fails++; $display("FAIL b2b_readback got=%h want=%h", rdata_s, d);
      end
      ref_hw[32'({a, 1'b0})] = d[15:0];
      ref_hw[32'({a, 1'b1})] = d[31:16];
   endtask

   task automatic test_reset_mid();
      abort_txn(1'b0, 18'h3FFFF, 32'h0, 3, 1'b0, "reset_lo_read");
   endtask

   task automatic test_reset_hi_write();
      abort_txn(1'b1, 18'h00100, 32'h55AA33CC, 6, 1'b1, "reset_hi_write");
      run_txn(1'b0, 18'h00100, 32'h0, "after_abort_read");
      run_txn(1'b1, 18'h00101, 32'h0BADF00D, "after_abort_write");
   endtask

   task automatic test_wait1();
      logic [17:0] a = 18'($urandom);
      logic [31:0] d = $urandom;
      @(negedge sck);
      sel = 1'b1;
      run_txn(1'b1, a, d, "w1_write");
      run_txn(1'b0, a, 32'h0, "w1_read");
      run_txn(1'b0, 18'h3FFFF, 32'h0, "w1_read_top");
      @(negedge sck);
      sel = 1'b0;
   endtask

   task automatic test_random();
      for (int unsigned i = 0; i < 16; i++) begin
         logic [17:0] a;
         a = ($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom_range(0, 7));
         run_txn(1'($urandom_range(0, 1)), a, $urandom, "random");
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_mid();
      test_reset_hi_write();
      test_wait1();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
